// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, runs one memory read per fetch
// request and strobes the IR load while the word is on the data bus.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    WAIT_LIMIT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch,
  input  logic                  pcLoad,
  input  logic [ADDR_WIDTH-1:0] pcIn,
  input  logic                  memReady,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  notMemRead,
  output logic                  notIrLoad,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       wait_expired;

  assign wait_expired = (wait_cnt == CNT_LAST) && !memReady;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (fetch) state_nxt = S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (memReady)          state_nxt = S_LOAD;
        else if (wait_expired) state_nxt = S_IDLE;
      end
      S_LOAD: state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A jump and a fetch in the same cycle fetch from the jump target.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      memAddr  <= RESET_PC;
      timeout  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pcLoad) pc <= pcIn;
          if (fetch) begin
            memAddr  <= pcLoad ? pcIn : pc;
            timeout  <= 1'b0;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (wait_expired)   timeout  <= 1'b1;
          else if (!memReady) wait_cnt <= wait_cnt + 8'd1;
        end
        S_LOAD: pc <= pc + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    notMemRead = 1'b1;
    notIrLoad  = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_IDLE: busy       = 1'b0;
      S_REQ:  notMemRead = 1'b0;
      S_WAIT: notMemRead = 1'b0;
      S_LOAD: begin
        notMemRead = 1'b0;
        notIrLoad  = 1'b0;
      end
      S_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table plus scoreboard of expected
// fetch outcomes, and a hand-written reset-during-WAIT sequence.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch;
  logic        pcLoad;
  logic [15:0] pcIn;
  logic        memReady;
  logic [15:0] memAddr;
  logic        notMemRead;
  logic        notIrLoad;
  logic [15:0] pc;
  logic        busy;
  logic        done;
  logic        timeout;

  logic [15:0] bus;
  logic [15:0] ir;
  logic [15:0] model_ir;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign bus = memAddr ^ 16'hAF73;

  always @(posedge clock)
    if (!notIrLoad) ir <= bus;

  instruction_fetch #(
    .ADDR_WIDTH(16),
    .RESET_PC  (16'h0000),
    .WAIT_LIMIT(15)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .fetch     (fetch),
    .pcLoad    (pcLoad),
    .pcIn      (pcIn),
    .memReady  (memReady),
    .memAddr   (memAddr),
    .notMemRead(notMemRead),
    .notIrLoad (notIrLoad),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  typedef struct {
    logic        ld;
    logic [15:0] pin;
    logic        fe;
    int          delay;
    logic        noise;
    logic [15:0] addr;
    logic [15:0] pc;
    int          done_cyc;
    int          end_cyc;
    logic        to;
    int          irl;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [15:0] ir;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e;
    int          done_at;
    int          end_at;
    int          irl;
    logic [15:0] addr_req;
    e.v  = v;
    e.ir = (v.done_cyc != 0) ? (v.addr ^ 16'hAF73) : model_ir;
    model_ir = e.ir;
    sb.push_back(e);
    done_at  = 0;
    end_at   = 0;
    irl      = 0;
    addr_req = 'x;
    pcLoad   = v.ld;
    pcIn     = v.pin;
    fetch    = v.fe;
    memReady = (v.delay == 0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      fetch    = 1'b0;
      pcLoad   = 1'b0;
      if (v.noise && c == 3) begin
        fetch  = 1'b1;
        pcLoad = 1'b1;
        pcIn   = 16'h5555;
      end
      memReady = (c >= 2 + v.delay);
      if (c == 1) addr_req = memAddr;
      if (!notIrLoad) irl++;
      if (done && done_at == 0) done_at = c;
      if (!busy) begin
        end_at = c;
        break;
      end
    end
    fetch    = 1'b0;
    pcLoad   = 1'b0;
    memReady = 1'b0;
    if (end_at == 0)
      $display("FAIL v%0d_hang: got busy expected idle", idx);
    e = sb.pop_front();
    check($sformatf("v%0d_end_cycle", idx), end_at, e.v.end_cyc);
    check($sformatf("v%0d_done_cycle", idx), done_at, e.v.done_cyc);
    check($sformatf("v%0d_irload_cnt", idx), irl, e.v.irl);
    check($sformatf("v%0d_addr_req", idx), addr_req, e.v.addr);
    check($sformatf("v%0d_addr_end", idx), memAddr, e.v.addr);
    check($sformatf("v%0d_pc", idx), pc, e.v.pc);
    check($sformatf("v%0d_timeout", idx), timeout, e.v.to);
    check($sformatf("v%0d_ir", idx), ir, e.ir);
  endtask

  initial begin
    int dn;
    int il;
    reset    = 1'b1;
    fetch    = 1'b0;
    pcLoad   = 1'b0;
    pcIn     = '0;
    memReady = 1'b0;
    model_ir = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_notMemRead", notMemRead, 1);
    check("rst_notIrLoad", notIrLoad, 1);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_pc", pc, 16'h0000);
    check("rst_memAddr", memAddr, 16'h0000);

    vecs[0] = '{1'b0, 16'h0000, 1'b1, 0, 1'b0,
                16'h0000, 16'h0001, 4, 5, 1'b0, 1};
    vecs[1] = '{1'b1, 16'h1234, 1'b1, 0, 1'b0,
                16'h1234, 16'h1235, 4, 5, 1'b0, 1};
    vecs[2] = '{1'b1, 16'hFFFF, 1'b1, 0, 1'b0,
                16'hFFFF, 16'h0000, 4, 5, 1'b0, 1};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 99, 1'b0,
                16'h0000, 16'h0000, 0, 17, 1'b1, 0};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 3, 1'b1,
                16'h0000, 16'h0001, 7, 8, 1'b0, 1};
    vecs[5] = '{1'b1, 16'h00A0, 1'b0, 0, 1'b0,
                16'h0000, 16'h00A0, 0, 1, 1'b0, 0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1, 1'b0,
                16'h00A0, 16'h00A1, 5, 6, 1'b0, 1};

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // reset while waiting on memory aborts the read
    fetch = 1'b1;
    @(posedge clock);
    #1;
    fetch = 1'b0;
    @(posedge clock);
    #1;
    check("wr_in_wait_busy", busy, 1);
    check("wr_in_wait_addr", memAddr, 16'h00A1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("wr_busy", busy, 0);
    check("wr_notMemRead", notMemRead, 1);
    check("wr_pc", pc, 16'h0000);
    check("wr_memAddr", memAddr, 16'h0000);
    check("wr_done", done, 0);
    check("wr_timeout", timeout, 0);
    dn = 0;
    il = 0;
    memReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      #1;
      if (done) dn++;
      if (!notIrLoad) il++;
    end
    memReady = 1'b0;
    check("wr_no_done", dn, 0);
    check("wr_no_irload", il, 0);
    check("wr_pc_hold", pc, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
